// File: rtl/requant_if.sv
// Stream and configuration bundle for requant_unit: table writes, accumulator input
// stream and requantized output stream.
interface requant_if #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MULT_W  = 16,
    parameter int unsigned SHIFT_W = 6,
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned CH_W    = $clog2(NUM_CH)
) ();
    logic                     cfg_we;
    logic [CH_W-1:0]          cfg_ch;
    logic [MULT_W-1:0]        cfg_mult;
    logic [SHIFT_W-1:0]       cfg_shift;
    logic                     i_valid;
    logic                     i_ready;
    logic signed [ACC_W-1:0]  i_acc;
    logic                     i_last;
    logic                     o_valid;
    logic                     o_ready;
    logic signed [DATA_W-1:0] o_data;
    logic [CH_W-1:0]          o_ch;

    modport master (
        output cfg_we, cfg_ch, cfg_mult, cfg_shift, i_valid, i_acc, i_last, o_ready,
        input  i_ready, o_valid, o_data, o_ch
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_mult, cfg_shift, i_valid, i_acc, i_last, o_ready,
        output i_ready, o_valid, o_data, o_ch
    );
endinterface

// File: rtl/requant_unit.sv
// Three-stage requantizer: per-channel multiply, round-half-up right shift, saturate to DATA_W.
// Define REQUANT_SAT_CNT_EN to add the o_sat_cnt clipped-output counter port.
module requant_unit #(
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MULT_W  = 16,
    parameter int unsigned SHIFT_W = 6,
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned CH_W    = $clog2(NUM_CH)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef REQUANT_SAT_CNT_EN
    output logic [15:0] o_sat_cnt,
`endif
    requant_if.slave    bus
);
    localparam int unsigned PROD_W = ACC_W + MULT_W + 1;
    // One spare bit so the rounding addend can never overflow.
    localparam int unsigned EXT_W  = PROD_W + 1;
    localparam logic signed [EXT_W-1:0] SatMax = EXT_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SatMin = ~SatMax;

    logic [MULT_W-1:0]  mult_q  [NUM_CH];
    logic [SHIFT_W-1:0] shift_q [NUM_CH];

    logic [CH_W-1:0] ch_q, ch_d;
    logic            en, accept;

    logic                     s1_valid_q;
    logic signed [ACC_W-1:0]  s1_acc_q;
    logic [CH_W-1:0]          s1_ch_q;
    logic [MULT_W-1:0]        s1_mult_q;
    logic [SHIFT_W-1:0]       s1_shift_q;

    logic                     s2_valid_q;
    logic signed [PROD_W-1:0] s2_prod_q;
    logic [CH_W-1:0]          s2_ch_q;
    logic [SHIFT_W-1:0]       s2_shift_q;

    logic                     o_valid_q;
    logic signed [DATA_W-1:0] o_data_q;
    logic [CH_W-1:0]          o_ch_q;

    logic signed [PROD_W-1:0] prod_d;
    logic signed [EXT_W-1:0]  wide, rounded;
    logic signed [DATA_W-1:0] sat_res;
    int unsigned              sh;

    assign en          = !o_valid_q || bus.o_ready;
    assign accept      = bus.i_valid && en;
    assign bus.i_ready = en;
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_ch    = o_ch_q;

    // Same-edge write means a word accepted this cycle still reads the old entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                mult_q[i]  <= '0;
                shift_q[i] <= '0;
            end
        end else if (bus.cfg_we && (int'(bus.cfg_ch) < int'(NUM_CH))) begin
            mult_q[bus.cfg_ch]  <= bus.cfg_mult;
            shift_q[bus.cfg_ch] <= bus.cfg_shift;
        end
    end

    always_comb begin
        ch_d = ch_q;
        if (accept) begin
            if (bus.i_last || (ch_q == CH_W'(NUM_CH - 1))) ch_d = '0;
            else                                           ch_d = ch_q + CH_W'(1);
        end
    end

    always_comb begin
        prod_d = PROD_W'(s1_acc_q) * PROD_W'($signed({1'b0, s1_mult_q}));
    end

    // Shifts at or beyond the product width all round to zero, so clamp there.
    always_comb begin
        sh = 32'(s2_shift_q);
        if (sh > PROD_W) sh = PROD_W;
        wide = EXT_W'(s2_prod_q);
        if (sh != 0) wide = wide + (EXT_W'(1) << (sh - 1));
        rounded = wide >>> sh;
        sat_res = rounded[DATA_W-1:0];
        if (rounded > SatMax)      sat_res = SatMax[DATA_W-1:0];
        else if (rounded < SatMin) sat_res = SatMin[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_acc_q   <= '0;
            s1_ch_q    <= '0;
            s1_mult_q  <= '0;
            s1_shift_q <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_ch_q    <= '0;
            s2_shift_q <= '0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            o_ch_q     <= '0;
        end else if (en) begin
            ch_q       <= ch_d;
            s1_valid_q <= bus.i_valid;
            s1_acc_q   <= bus.i_acc;
            s1_ch_q    <= ch_q;
            s1_mult_q  <= mult_q[ch_q];
            s1_shift_q <= shift_q[ch_q];
            s2_valid_q <= s1_valid_q;
            s2_prod_q  <= prod_d;
            s2_ch_q    <= s1_ch_q;
            s2_shift_q <= s1_shift_q;
            o_valid_q  <= s2_valid_q;
            o_data_q   <= s2_valid_q ? sat_res : '0;
            o_ch_q     <= s2_valid_q ? s2_ch_q : '0;
        end
    end

`ifdef REQUANT_SAT_CNT_EN
    logic        sat_hit, o_sat_q;
    logic [15:0] sat_cnt_q;

    assign sat_hit   = s2_valid_q && ((rounded > SatMax) || (rounded < SatMin));
    assign o_sat_cnt = sat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_sat_q   <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (en) o_sat_q <= sat_hit;
            if (o_valid_q && bus.o_ready && o_sat_q && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_q <= sat_cnt_q + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_requant_unit.sv
// Directed bench for requant_unit with a 4-channel table.
module tb_requant_unit;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned MULT_W  = 16;
    localparam int unsigned SHIFT_W = 6;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_W    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    requant_if #(.ACC_W(ACC_W), .DATA_W(DATA_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W),
                 .NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

`ifdef REQUANT_SAT_CNT_EN
    logic [15:0] sat_cnt;
`endif

    requant_unit #(.ACC_W(ACC_W), .DATA_W(DATA_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W),
                   .NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef REQUANT_SAT_CNT_EN
        .o_sat_cnt(sat_cnt),
`endif
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;
    logic signed [DATA_W-1:0] q_data[$];
    logic [CH_W-1:0]          q_ch[$];

    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.o_ready) begin
            q_data.push_back(bus.o_data);
            q_ch.push_back(bus.o_ch);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_ch.delete();
    endtask

    task automatic stop_in();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_acc   = '0;
    endtask

    task automatic cfg(input int ch, input int mult, input int shift);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_mult  = MULT_W'(mult);
        bus.cfg_shift = SHIFT_W'(shift);
        step();
        bus.cfg_we = 1'b0;
    endtask

    // Holds the word until an edge at which i_ready was high; leaves i_valid asserted.
    task automatic send(input int acc, input logic last);
        logic rdy;
        int   n;
        bus.i_valid = 1'b1;
        bus.i_acc   = ACC_W'(acc);
        bus.i_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.i_ready;
            step();
            n++;
        end while (!rdy && n < 100);
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_accept: i_ready=%b after %0d cycles, required 1", rdy, n);
        end
    endtask

    task automatic wait_out(input int n);
        for (int i = 0; i < 100 && q_data.size() < n; i++) step();
        checks++;
        if (q_data.size() < n) begin
            errors++;
            $display("FAIL wait_out: got %0d outputs, required %0d", q_data.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.o_valid !== 1'b0) begin
            errors++; $display("FAIL reset_o_valid: got %b required 0", bus.o_valid);
        end
        checks++;
        if (bus.o_data !== 8'sd0) begin
            errors++; $display("FAIL reset_o_data: got %0d required 0", bus.o_data);
        end
        checks++;
        if (bus.o_ch !== 2'd0) begin
            errors++; $display("FAIL reset_o_ch: got %0d required 0", bus.o_ch);
        end
        checks++;
        if (bus.i_ready !== 1'b1) begin
            errors++; $display("FAIL reset_i_ready: got %b required 1", bus.i_ready);
        end
`ifdef REQUANT_SAT_CNT_EN
        checks++;
        if (sat_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_sat_cnt: got %0d required 0", sat_cnt);
        end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_latency();
        logic exp_v[3];
        exp_v = '{1'b0, 1'b0, 1'b1};
        clear_q();
        cfg(0, 16384, 15);
        send(200, 1'b1);
        stop_in();
        for (int c = 0; c < 3; c++) begin
            if (c > 0) step();
            checks++;
            if (bus.o_valid !== exp_v[c]) begin
                errors++;
                $display("FAIL latency_valid_c%0d: got %b required %b", c + 1, bus.o_valid, exp_v[c]);
            end
        end
        checks++;
        if (bus.o_data !== 8'sd100) begin
            errors++; $display("FAIL latency_data: got %0d required 100", bus.o_data);
        end
        checks++;
        if (bus.o_ch !== 2'd0) begin
            errors++; $display("FAIL latency_ch: got %0d required 0", bus.o_ch);
        end
        step();
    endtask

    task automatic test_rounding();
        logic signed [DATA_W-1:0] exp_d[3];
        int acc[3];
        exp_d = '{8'sd2, -8'sd1, -8'sd2};
        acc   = '{3, -3, -4};
        clear_q();
        cfg(0, 1, 1);
        for (int k = 0; k < 3; k++) send(acc[k], 1'b1);
        stop_in();
        wait_out(3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q_data[k] !== exp_d[k] || q_ch[k] !== 2'd0) begin
                errors++;
                $display("FAIL round_%0d: got data=%0d ch=%0d required data=%0d ch=0",
                         acc[k], q_data[k], q_ch[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_saturation();
        clear_q();
        cfg(0, 16384, 15);
        send(1000, 1'b1);
        send(-1000, 1'b1);
        stop_in();
        wait_out(2);
        step();
        checks++;
        if (q_data[0] !== 8'sd127) begin
            errors++; $display("FAIL sat_high: got %0d required 127", q_data[0]);
        end
        checks++;
        if (q_data[1] !== -8'sd128) begin
            errors++; $display("FAIL sat_low: got %0d required -128", q_data[1]);
        end
`ifdef REQUANT_SAT_CNT_EN
        checks++;
        if (sat_cnt !== 16'd2) begin
            errors++; $display("FAIL sat_cnt: got %0d required 2", sat_cnt);
        end
`endif
    endtask

    task automatic test_channels();
        logic [CH_W-1:0] exp_c[6];
        logic            lst[6];
        exp_c = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
        lst   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        clear_q();
        for (int k = 0; k < 6; k++) send(0, lst[k]);
        stop_in();
        wait_out(6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (q_ch[k] !== exp_c[k]) begin
                errors++;
                $display("FAIL chan_word%0d: got ch=%0d required ch=%0d", k, q_ch[k], exp_c[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic signed [DATA_W-1:0] d0;
        logic [CH_W-1:0]          c0;
        for (int c = 0; c < int'(NUM_CH); c++) cfg(c, 1, 0);
        clear_q();
        fork
            begin
                for (int k = 0; k < 8; k++) send(k + 1, 1'b0);
                stop_in();
            end
            begin
                repeat (4) step();
                bus.o_ready = 1'b0;
                d0 = bus.o_data;
                c0 = bus.o_ch;
                checks++;
                if (bus.o_valid !== 1'b1) begin
                    errors++; $display("FAIL stall_start_valid: got %b required 1", bus.o_valid);
                end
                for (int s = 0; s < 5; s++) begin
                    step();
                    checks++;
                    if (bus.o_valid !== 1'b1 || bus.o_data !== d0 || bus.o_ch !== c0) begin
                        errors++;
                        $display("FAIL stall_hold_%0d: got v=%b d=%0d ch=%0d required v=1 d=%0d ch=%0d",
                                 s, bus.o_valid, bus.o_data, bus.o_ch, d0, c0);
                    end
                    checks++;
                    if (bus.i_ready !== 1'b0) begin
                        errors++; $display("FAIL stall_i_ready_%0d: got %b required 0", s, bus.i_ready);
                    end
                end
                bus.o_ready = 1'b1;
            end
        join
        wait_out(8);
        checks++;
        if (q_data.size() != 8) begin
            errors++; $display("FAIL stream_count: got %0d required 8", q_data.size());
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (q_data[k] !== 8'(k + 1) || q_ch[k] !== 2'(k % 4)) begin
                errors++;
                $display("FAIL stream_word%0d: got d=%0d ch=%0d required d=%0d ch=%0d",
                         k, q_data[k], q_ch[k], k + 1, k % 4);
            end
        end
    endtask

    task automatic test_cfg_same_cycle();
        clear_q();
        send(0, 1'b0);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'd1;
        bus.cfg_mult  = 16'd2;
        bus.cfg_shift = 6'd0;
        send(10, 1'b1);
        bus.cfg_we = 1'b0;
        send(0, 1'b0);
        send(10, 1'b0);
        stop_in();
        wait_out(4);
        checks++;
        if (q_data[1] !== 8'sd10 || q_ch[1] !== 2'd1) begin
            errors++;
            $display("FAIL cfg_old_value: got d=%0d ch=%0d required d=10 ch=1", q_data[1], q_ch[1]);
        end
        checks++;
        if (q_data[3] !== 8'sd20 || q_ch[3] !== 2'd1) begin
            errors++;
            $display("FAIL cfg_new_value: got d=%0d ch=%0d required d=20 ch=1", q_data[3], q_ch[3]);
        end
    endtask

    task automatic test_reset_midstream();
        clear_q();
        send(5, 1'b0);
        send(6, 1'b0);
        send(7, 1'b0);
        stop_in();
        rst = 1'b1;
        step();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_data !== 8'sd0) begin
            errors++;
            $display("FAIL midrst_out: got v=%b d=%0d required v=0 d=0", bus.o_valid, bus.o_data);
        end
`ifdef REQUANT_SAT_CNT_EN
        checks++;
        if (sat_cnt !== 16'd0) begin
            errors++; $display("FAIL midrst_sat_cnt: got %0d required 0", sat_cnt);
        end
`endif
        rst = 1'b0;
        clear_q();
        repeat (5) step();
        checks++;
        if (q_data.size() != 0) begin
            errors++; $display("FAIL midrst_discard: got %0d outputs required 0", q_data.size());
        end
        send(50, 1'b0);
        stop_in();
        wait_out(1);
        checks++;
        if (q_ch[0] !== 2'd0) begin
            errors++; $display("FAIL midrst_ch: got %0d required 0", q_ch[0]);
        end
        checks++;
        if (q_data[0] !== 8'sd0) begin
            errors++; $display("FAIL midrst_table: got %0d required 0", q_data[0]);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_ch    = '0;
        bus.cfg_mult  = '0;
        bus.cfg_shift = '0;
        bus.o_ready   = 1'b1;
        stop_in();
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_channels();
        test_back_to_back();
        test_cfg_same_cycle();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/requant_unit.md
Name: requant_unit

Overview:
- Requantization stage directly upstream of the hard-sigmoid activation unit.
- Accepts signed accumulator words from the MAC array and applies a per-channel multiplier and right-shift with rounding.
- Saturates each result to signed DATA_W, the Q1.7 activation input format.
- 3-stage pipeline with valid/ready backpressure and a runtime-writable per-channel scale table.

Parameters:
ACC_W, 32, accumulator input width (signed)
DATA_W, 8, output width (signed, Q1.7 at default)
MULT_W, 16, per-channel multiplier width (unsigned)
SHIFT_W, 6, per-channel shift width (unsigned)
NUM_CH, 16, number of channels in the table (>=2)
CH_W, $clog2(NUM_CH), channel index width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cfg_we  input  1  table write strobe
cfg_ch  input  CH_W  table write index
cfg_mult  input  MULT_W  multiplier to store
cfg_shift  input  SHIFT_W  shift to store
i_valid  input  1  input word valid
i_ready  output  1  input accepted when i_valid && i_ready
i_acc  input  ACC_W  signed accumulator value
i_last  input  1  last word of frame; channel counter restarts after it
o_valid  output  1  output valid
o_ready  input  1  downstream ready
o_data  output  DATA_W  signed requantized result
o_ch  output  CH_W  channel index of o_data

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all stage valids 0, o_valid=0, o_data=0, o_ch=0, channel counter 0, all table entries mult=0 and shift=0. Reset mid-stream discards in-flight words and produces no output.
- Pipeline enable: en = !o_valid || o_ready; i_ready = en (combinational). All stages advance only when en=1. When o_valid=1 and o_ready=0, o_data, o_ch and o_valid hold stable.
- Latency: 3 cycles from accept to o_valid under no backpressure. Throughput: 1 word/cycle.
- S1: register i_acc, current channel, table mult and shift for that channel.
- S2: product = i_acc * mult. Signed x unsigned, held in ACC_W+MULT_W+1 bits, no overflow.
- S3: if shift>0, add 1<<(shift-1), then arithmetic shift right by shift (round half toward +inf). Shift=0 passes the product unchanged. Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Channel counter:
  - Increments on each accepted word; wraps NUM_CH-1 -> 0.
  - Accepted word with i_last=1 forces the next channel to 0, regardless of position.
- Table write: when cfg_we=1, entry cfg_ch is updated at the clock edge. A word accepted in the same cycle for the same channel uses the old value; words accepted on later cycles use the new one. cfg_ch >= NUM_CH is ignored.
- Bubbles: invalid stages carry o_data=0 and do not advance the channel counter.

Optional Feature:
- Macro: REQUANT_SAT_CNT_EN.
- Defined:
  - Adds output port o_sat_cnt (16 bits).
  - Counts words leaving S3 (o_valid && o_ready) whose value was clipped at either bound.
  - Saturates at 16'hFFFF; cleared by rst.
- Not defined: port absent, no counter logic.

Test Plan:
- Ch0 mult=16384, shift=15; i_acc=200 -> o_data=100, o_ch=0, 3 cycles after accept.
- Ch0 mult=1, shift=1; i_acc=3,-3,-4 -> o_data=2,-1,-2 (round half up).
- Ch0 mult=16384, shift=15; i_acc=1000,-1000 -> o_data=127,-128; with REQUANT_SAT_CNT_EN, o_sat_cnt=2.
- NUM_CH=4; 6 back-to-back words, i_last on word 2 -> o_ch = 0,1,0,1,2,3.
- Continuous stream, o_ready low for 5 cycles -> o_data stable, i_ready=0 during stall, no words lost or duplicated, order preserved.
- Write ch1 mult=2, shift=0 in the same cycle a ch1 word (i_acc=10) is accepted, old mult=1 -> first output 10, next ch1 word (i_acc=10) -> 20. Assert rst mid-stream -> o_valid=0 next cycle, next output o_ch=0, table zeroed (o_data=0).
